// File: rtl/ctrl_fetch_unit.sv
`default_nettype none
// ctrl_fetch_unit: multi-cycle PC/fetch/decode sequencer driving the 16-bit datapath controls (rev 1.0).
// Build option CTRL_ILLEGAL_TRAP_EN: opcode 111 parks the core in HALT with a sticky Halted flag.
module ctrl_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clock_i,
  input  logic        Reset_i,
  output logic [15:0] ImemAddr_o,
  output logic        ImemReq_o,
  input  logic        ImemReady_i,
  input  logic [15:0] ImemData_i,
  output logic [15:0] Instruction_o,
  output logic [15:0] PC_o,
  output logic        RegDest_o,
  output logic        ALUSrc_o,
  output logic        MemToReg_o,
  output logic        RegWrite_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        Branch_o,
  output logic [1:0]  AluOp_o,
  input  logic        Zero_i,
  output logic        Halted_o
);

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_BNE   = 3'b101;
  localparam logic [2:0] OP_J     = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;

  logic [2:0]  w_opcode;
  logic [6:0]  w_imm;
  logic [15:0] w_pc_plus2;
  logic [15:0] w_br_target;
  logic [15:0] w_jmp_target;
  logic        w_illegal;
  logic        w_active;

  assign w_opcode     = instr_q[15:13];
  assign w_imm        = instr_q[6:0];
  assign w_illegal    = (w_opcode == OP_ILL);
  assign w_pc_plus2   = pc_q + 16'd2;
  // Sign-extended immediate scaled to a byte offset; the add wraps modulo 2^16.
  assign w_br_target  = w_pc_plus2 + {{8{w_imm[6]}}, w_imm, 1'b0};
  assign w_jmp_target = {w_pc_plus2[15:14], instr_q[12:0], 1'b0};

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic halted_q, halted_d;
`endif

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= 16'h0000;
`ifdef CTRL_ILLEGAL_TRAP_EN
      halted_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      halted_q <= halted_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    halted_d = halted_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (ImemReady_i) begin
          instr_d = ImemData_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          halted_d = 1'b1;
          state_d  = S_HALT;
`else
          pc_d    = w_pc_plus2;
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (w_opcode)
          OP_RTYPE, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:      state_d = S_MEM;
          OP_BEQ: begin
            pc_d    = Zero_i ? w_br_target : w_pc_plus2;
            state_d = S_FETCH;
          end
          OP_BNE: begin
            pc_d    = !Zero_i ? w_br_target : w_pc_plus2;
            state_d = S_FETCH;
          end
          OP_J: begin
            pc_d    = w_jmp_target;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (w_opcode == OP_SW) begin
          pc_d    = w_pc_plus2;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d    = w_pc_plus2;
        state_d = S_FETCH;
      end
      S_HALT: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        state_d = S_HALT;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Static decode is qualified by state so it is quiet while fetching and while halted.
  assign w_active = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                    (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    RegDest_o  = 1'b0;
    ALUSrc_o   = 1'b0;
    MemToReg_o = 1'b0;
    AluOp_o    = ALU_ADD;
    RegWrite_o = 1'b0;
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    Branch_o   = 1'b0;
    if (w_active) begin
      case (w_opcode)
        OP_RTYPE: begin
          RegDest_o = 1'b1;
          AluOp_o   = ALU_FUNCT;
        end
        OP_ADDI, OP_SW: ALUSrc_o = 1'b1;
        OP_LW: begin
          ALUSrc_o   = 1'b1;
          MemToReg_o = 1'b1;
        end
        OP_BEQ, OP_BNE: AluOp_o = ALU_SUB;
        default: ;
      endcase
    end
    RegWrite_o = (state_q == S_WB);
    MemRead_o  = (state_q == S_MEM) && (w_opcode == OP_LW);
    MemWrite_o = (state_q == S_MEM) && (w_opcode == OP_SW);
    Branch_o   = (state_q == S_EXEC) && ((w_opcode == OP_BEQ) || (w_opcode == OP_BNE));
  end

  // Request is held off while reset is asserted so it first rises after release.
  assign ImemReq_o     = (state_q == S_FETCH) && !Reset_i;
  assign ImemAddr_o    = pc_q;
  assign PC_o          = pc_q;
  assign Instruction_o = instr_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign Halted_o = halted_q;
`else
  assign Halted_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/ctrl_fetch_unit.md
# ctrl_fetch_unit

Multi-cycle control and instruction-fetch unit for the 16-bit CPU. It owns the PC, fetches 16-bit instructions over a ready handshake, and decodes the 3-bit opcode. It sequences the datapath control strobes (RegDest, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, AluOp, Branch) and updates the PC from the datapath's Zero flag. It is the driving end of the datapath control interface.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- Clock  in  1  single system clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- ImemAddr  out  16  fetch address; equals PC.
- ImemReq  out  1  fetch request.
- ImemReady  in  1  fetch data valid on ImemData.
- ImemData  in  16  fetched instruction.
- Instruction  out  16  latched instruction register, fed to the datapath.
- PC  out  16  current program counter.
- RegDest, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  datapath controls.
- AluOp  out  2  00 add, 01 sub, 10 use Funct.
- Zero  in  1  ALU zero flag from the datapath.
- Halted  out  1  sticky illegal-opcode trap. Only present with CTRL_ILLEGAL_TRAP_EN; otherwise tied to 0.

## Operation
- Instruction fields: OpCode[15:13], RS[12:10], RT[9:7], RD[6:4], Funct[3:0], Imm[6:0].
- Opcodes:
  - 000 R-type: RegDest=1, AluOp=10, RegWrite.
  - 001 ADDI: ALUSrc=1, AluOp=00, RegWrite.
  - 010 LW: ALUSrc=1, AluOp=00, MemRead, MemToReg=1, RegWrite.
  - 011 SW: ALUSrc=1, AluOp=00, MemWrite.
  - 100 BEQ and 101 BNE: AluOp=01, Branch.
  - 110 J: no datapath activity.
  - 111: illegal.
- The PC is byte-addressed. PCplus2 = PC+2, modulo 2^16, wraps silently.
- Branch target = PCplus2 + ({9{Imm[6]},Imm} << 1), truncated to 16 bits.
- Jump target = {PCplus2[15:14], Instruction[12:0], 1'b0}.
- State machine:
  - FETCH: ImemReq=1. On ImemReady, latch ImemData into Instruction and go to DECODE.
  - DECODE: go to EXEC. If the opcode is 111, go to FETCH instead.
  - EXEC:
    - R-type, ADDI: go to WB.
    - LW, SW: go to MEM.
    - BEQ: PC <= Zero ? target : PCplus2, then FETCH.
    - BNE: PC <= !Zero ? target : PCplus2, then FETCH.
    - J: PC <= jump target, then FETCH.
  - MEM: MemRead or MemWrite is high for exactly one cycle. LW goes to WB. SW sets PC <= PCplus2 and goes to FETCH.
  - WB: RegWrite=1 for one cycle. PC <= PCplus2, then FETCH.
- Static decode outputs (RegDest, ALUSrc, MemToReg, AluOp) are held from DECODE through the last cycle of the instruction.
- Strobes (RegWrite, MemRead, MemWrite, Branch) are high only in their own state. Branch is high in EXEC.
- An illegal opcode without the trap behaves as a NOP: PC <= PCplus2, back to FETCH.

## Timing
- Reset values:
  - PC = RESET_PC, state = FETCH.
  - Instruction = 16'h0000, Halted = 0.
  - All strobes = 0; AluOp = 00; RegDest, ALUSrc, MemToReg = 0.
  - ImemReq goes high on the first cycle after Reset deasserts.
- Fetch handshake:
  - ImemAddr is stable while ImemReq=1.
  - The transfer completes on the first rising edge with ImemReq && ImemReady. ImemReq drops in the following cycle.
  - ImemReady while ImemReq=0 is ignored.
  - Any number of wait cycles is allowed.
- Latency, counted from the fetch-accept edge to the next ImemReq: R-type/ADDI 3, LW 4, SW 3, BEQ/BNE/J 2, illegal 1 cycle.
- Zero is sampled only at the EXEC clock edge of a branch.
- Reset mid-instruction aborts it immediately. Strobes drop asynchronously, and no partial PC update occurs.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: opcode 111 sets Halted=1 in DECODE, and the FSM parks in a HALT state.
  - In HALT, ImemReq=0 and all strobes are 0; PC stays frozen at the illegal instruction's address.
  - Only Reset exits HALT.
- Not defined: opcode 111 is a NOP and Halted is constant 0.

## Test plan
- Reset with RESET_PC=16'h0040 -> PC=0x0040, ImemReq=1 in the first cycle after release, all strobes 0.
- R-type 16'h0412 with 3 ImemReady wait cycles -> RegDest=1, AluOp=10, a single RegWrite pulse in WB, PC 0x0040→0x0042.
- LW 16'h4483 -> one MemRead cycle, then a RegWrite cycle with MemToReg=1; ALUSrc=1 throughout; PC+2.
- BEQ with Imm=7'h7E (-2) at PC=0x0010: Zero=1 gives PC=0x000E; Zero=0 gives PC=0x0012. BNE gives the inverse.
- J 16'hC005 at PC=0xFFFE -> PCplus2 wraps to 0x0000, giving target 0x000A.
- Opcode 111: with the macro, Halted=1, ImemReq stays 0, PC is unchanged until Reset. Without the macro, PC+2 and fetch resumes. A Reset asserted during the MEM state of an SW aborts the instruction, and no further MemWrite pulse occurs.
